// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the normalizer and its neighbours (state
// encoding, word/shift widths, shift-type codes also used by the barrel shifter).
package cpu_pkg;

  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int STEPS   = 5;
  localparam logic [SHAMT_W-1:0] FIRST_STEP = 5'd16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } norm_state_e;

  typedef enum logic [1:0] {
    SHIFT_LEFT  = 2'b00,
    SHIFT_RIGHT = 2'b01
  } shift_type_e;

endpackage

// File: rtl/norm_step.sv
// One binary-search step of the normalizer: tests the outer 'step' bits of the
// word on the side selected by dir_i and shifts them out when they are all zero.
module norm_step
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0]  work_i,
  input  logic [SHAMT_W-1:0] step_i,
  input  logic [1:0]         dir_i,
  output logic [WORD_W-1:0]  work_o,
  output logic               hit_o
);

  localparam logic [WORD_W-1:0] ONE = 1;

  logic [WORD_W-1:0] low_mask;
  logic [WORD_W-1:0] top_bits;
  logic              right;

  always_comb begin
    right    = (dir_i == SHIFT_RIGHT);
    low_mask = (ONE << step_i) - ONE;
    // Upper 'step' bits moved down to the bottom so they can be tested for zero.
    top_bits = work_i >> (6'(WORD_W) - {1'b0, step_i});
    hit_o    = right ? ((work_i & low_mask) == '0) : (top_bits == '0);
    work_o   = work_i;
    if (hit_o) begin
      work_o = right ? (work_i >> step_i) : (work_i << step_i);
    end
  end

endmodule

// File: rtl/norm_shift_unit.sv
// Multi-cycle leading-zero normalizer: five binary-search steps (16,8,4,2,1),
// valid/ready on both sides. Define NORM_TRAILING_EN to add the in_dir port
// and a trailing-zero (right-justify) mode.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready; a
// result transfers on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE, and DONE holds its outputs until
// the result transfers.
module norm_shift_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef NORM_TRAILING_EN
  input  logic             in_dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_zero,
  output logic [1:0]       dbg_state
);

  norm_state_e      state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [2:0]       idx_q, idx_d;
  logic             dir_q, dir_d;

  logic [SHW-1:0]   step;
  logic [1:0]       shift_type;
  logic [WIDTH-1:0] step_work;
  logic             hit;

  assign step       = FIRST_STEP >> idx_q;
  assign shift_type = dir_q ? SHIFT_RIGHT : SHIFT_LEFT;

  norm_step u_step (
    .work_i (work_q),
    .step_i (step),
    .dir_i  (shift_type),
    .work_o (step_work),
    .hit_o  (hit)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          zero_d  = (in_data == '0);
          idx_d   = '0;
`ifdef NORM_TRAILING_EN
          dir_d   = in_dir;
`else
          dir_d   = 1'b0;
`endif
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          work_d = step_work;
          cnt_d  = cnt_q + step;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end

  // A zero word walks the count up to 31; report 0 instead.
  assign out_shamt = zero_q ? '0 : cnt_q;
  assign out_data  = work_q;
  assign out_zero  = zero_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_norm_shift_unit.sv
// Bench for norm_shift_unit: directed vectors, a cycle-level scoreboard of
// expected results and handshake timing, and literal spot checks.
module tb_norm_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_shamt;
  logic        out_zero;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  norm_shift_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef NORM_TRAILING_EN
    .in_dir    (in_dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout req=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%08h req=0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Result packed as {data[31:0], shamt[4:0], zero}.
  function automatic logic [37:0] model(input logic [31:0] x, input logic dir);
    int k;
    logic [31:0] d;
    k = 0;
    if (x == 32'd0) return {32'd0, 5'd0, 1'b1};
    if (!dir) begin
      while (x[31-k] == 1'b0) k++;
      d = x << k;
    end else begin
      while (x[k] == 1'b0) k++;
      d = x >> k;
    end
    return {d, 5'(k), 1'b0};
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [37:0] exp_q[$];
  bit          chk_en     = 0;
  bit          post_reset = 0;
  bit          busy       = 0;
  int          since      = 0;

  always @(negedge clk) begin
    logic [37:0] e;
    logic        exp_valid;
    if (busy) since++;
    if (chk_en) begin
      exp_valid = busy && (since >= 5);
      check("sb_in_ready", 32'(in_ready), 32'(!busy));
      check("sb_out_valid", 32'(out_valid), 32'(exp_valid));
      if (post_reset) begin
        check("sb_rst_state", 32'(dbg_state), 32'd0);
        check("sb_rst_data", out_data, 32'd0);
        check("sb_rst_shamt", 32'(out_shamt), 32'd0);
        check("sb_rst_zero", 32'(out_zero), 32'd0);
      end
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          e = exp_q[0];
          check("sb_data", out_data, e[37:6]);
          check("sb_shamt", 32'(out_shamt), 32'(e[5:1]));
          check("sb_zero", 32'(out_zero), 32'(e[0]));
        end
      end
    end
    post_reset = 0;
    // Plan the effect of the coming rising edge.
    if (!rst_n) begin
      chk_en     = 1;
      post_reset = 1;
      busy       = 0;
      exp_q.delete();
    end else if (!busy && in_valid) begin
      exp_q.push_back(model(in_data, in_dir));
      busy  = 1;
      since = -1;
    end else if (busy && since >= 5 && out_ready) begin
      busy = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [31:0] w, input logic dir);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    in_dir   = dir;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_dir   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) return;
    end
    check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] w, input logic dir);
    int lat;
    accept(w, dir);
    wait_result(lat);
    check("latency", 32'(lat), 32'd5);
    handshake();
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] vec [8];

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Model pins.
    check("model_a", model(32'h0000_0001, 1'b0)[37:1], {32'h8000_0000, 5'd31});
    check("model_b", 32'(model(32'h0000_0000, 1'b0)), 32'd1);

    // Single word 0x00000001.
    accept(32'h0000_0001, 1'b0);
    wait_result(lat);
    check("t1_lat", 32'(lat), 32'd5);
    check("t1_shamt", 32'(out_shamt), 32'd31);
    check("t1_data", out_data, 32'h8000_0000);
    check("t1_zero", 32'(out_zero), 32'd0);
    handshake();
    check("t1_idle", 32'(in_ready), 32'd1);

    // Back-to-back words, second held while busy.
    accept(32'h00F0_0000, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h8000_0000;
    in_dir   = 1'b0;
    wait_result(lat);
    check("t2a_lat", 32'(lat), 32'd5);
    check("t2a_shamt", 32'(out_shamt), 32'd8);
    check("t2a_data", out_data, 32'hF000_0000);
    check("t2a_in_ready", 32'(in_ready), 32'd0);
    handshake();
    accept(32'h8000_0000, 1'b0);
    wait_result(lat);
    check("t2b_shamt", 32'(out_shamt), 32'd0);
    check("t2b_data", out_data, 32'h8000_0000);
    handshake();

    // Zero word.
    accept(32'h0000_0000, 1'b0);
    wait_result(lat);
    check("t3_lat", 32'(lat), 32'd5);
    check("t3_zero", 32'(out_zero), 32'd1);
    check("t3_shamt", 32'(out_shamt), 32'd0);
    check("t3_data", out_data, 32'd0);
    handshake();

    // Backpressure with a pending input word.
    accept(32'h0000_0123, 1'b0);
    wait_result(lat);
    in_valid = 1'b1;
    in_data  = 32'h0000_0055;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      check("t4_hold_shamt", 32'(out_shamt), 32'd23);
      check("t4_hold_data", out_data, 32'h9180_0000);
    end
    in_valid = 1'b0;
    handshake();
    check("t4_idle_state", 32'(dbg_state), 32'd0);
    check("t4_idle_ready", 32'(in_ready), 32'd1);

    // Reset on the third SEARCH clock.
    accept(32'h0001_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_state", 32'(dbg_state), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    accept(32'h0001_0000, 1'b0);
    wait_result(lat);
    check("t5_shamt", 32'(out_shamt), 32'd15);
    check("t5_data", out_data, 32'h8000_0000);

    // Reset while stalled in DONE.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_data", out_data, 32'd0);

    // Assorted vectors, out_ready held high throughout.
    vec[0] = 32'hFFFF_FFFF; vec[1] = 32'h4000_0000;
    vec[2] = 32'h0000_8000; vec[3] = 32'h7FFF_FFFF;
    vec[4] = 32'h0000_0002; vec[5] = $urandom;
    vec[6] = $urandom >> $urandom_range(0, 31);
    vec[7] = 32'h0100_0001;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      accept(vec[i], 1'b0);
      wait_result(lat);
      check("t7_lat", 32'(lat), 32'd5);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;

`ifdef NORM_TRAILING_EN
    accept(32'h0000_0A00, 1'b1);
    wait_result(lat);
    check("t8_shamt", 32'(out_shamt), 32'd9);
    check("t8_data", out_data, 32'h0000_0005);
    handshake();
    run_one(32'h8000_0000, 1'b1);
    run_one(32'h0000_0000, 1'b1);
    run_one(32'hF000_0001, 1'b1);
`endif

    run_one(32'h0000_0400, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 32'(in_ready), 32'd1);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
